// File: rtl/game_pkg.sv
// game_pkg -- shared definitions for the game controller.
//   state_t      : FSM state encoding (IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4)
//   *_DEF        : default values for the controller parameters
//   sat_inc16    : 16-bit increment that sticks at all-ones
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_MISS  = 3'd3,
        ST_OVER  = 3'd4
    } state_t;

    localparam int LIVES_INIT_DEF    = 3;
    localparam int SERVE_FRAMES_DEF  = 120;
    localparam int MISS_FRAMES_DEF   = 60;
    localparam int SPEEDUP_EVERY_DEF = 8;

    localparam logic [2:0] SPEED_MAX = 3'd7;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/game_controller_frame_timer.sv
// frame_timer -- frame_tick down-counter shared by the SERVE and MISS waits.
//   clk, reset : clock, async active-high reset
//   load       : load load_val (has priority over clear and tick)
//   clear      : force the count to zero
//   tick       : count one frame (ignored once the count is zero)
//   load_val   : number of frames to wait
//   done       : terminal flag, high on the tick that completes the wait
module frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] load_val,
    output logic       done
);

    logic [7:0] count;

    // Last remaining frame is being consumed this cycle.
    assign done = tick && (count == 8'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (clear)
            count <= '0;
        else if (tick && (count != 8'd0))
            count <= count - 8'd1;
    end

endmodule

// File: rtl/game_controller.sv
// game_controller -- serve/play/miss/game-over sequencer for the puck game.
// Sits beside the pixel datapath; its score output drives the top-level
// score port in place of the datapath's raw collision count.
//   clk, reset  : clock, async active-high reset
//   start       : debounced start button (level)
//   frame_tick  : one pulse per video frame
//   hit, miss   : one-cycle puck/paddle events from the datapath
//   state       : FSM state encoding
//   play_en     : puck motion enable (PLAY only)
//   puck_reset  : one-cycle pulse that recentres the puck before a serve
//   speed       : puck speed level 1..7
//   lives       : remaining lives
//   score       : hits this game (saturating)
//   high_score  : best score since reset
//   game_over   : high while in OVER
module game_controller
    import game_pkg::*;
#(
    parameter int LIVES_INIT    = LIVES_INIT_DEF,
    parameter int SERVE_FRAMES  = SERVE_FRAMES_DEF,
    parameter int MISS_FRAMES   = MISS_FRAMES_DEF,
    parameter int SPEEDUP_EVERY = SPEEDUP_EVERY_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        frame_tick,
    input  logic        hit,
    input  logic        miss,
    output logic [2:0]  state,
    output logic        play_en,
    output logic        puck_reset,
    output logic [2:0]  speed,
    output logic [1:0]  lives,
    output logic [15:0] score,
    output logic [15:0] high_score,
    output logic        game_over
);

    state_t     st;
    logic       armed;     // start has been seen low since reset / last press
    logic       start_ev;
    logic [7:0] hit_cnt;

    logic       t_load, t_clear, t_tick, t_done;
    logic [7:0] t_val;

    assign state = st;

    // armed resets to 0, so a start level held through reset release must
    // first drop before it can count as a press.
    assign start_ev = start & armed;

    // Timer control. Ticks count only inside SERVE/MISS, and the timer is
    // reloaded on the transition cycle itself, so a tick landing on a
    // transition belongs to the state being left.
    always_comb begin
        t_tick  = frame_tick & ((st == ST_SERVE) || (st == ST_MISS));
        t_clear = (st == ST_IDLE) || (st == ST_OVER);
        t_load  = 1'b0;
        t_val   = 8'(SERVE_FRAMES);
        case (st)
            ST_IDLE, ST_OVER: t_load = start_ev;
            ST_MISS:          t_load = t_done;
            ST_PLAY: begin
                if (miss && (lives != 2'd1)) begin
                    t_load = 1'b1;
                    t_val  = 8'(MISS_FRAMES);
                end
            end
            default: ;
        endcase
    end

    frame_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .clear    (t_clear),
        .tick     (t_tick),
        .load_val (t_val),
        .done     (t_done)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st         <= ST_IDLE;
            armed      <= 1'b0;
            play_en    <= 1'b0;
            puck_reset <= 1'b0;
            speed      <= '0;
            lives      <= '0;
            score      <= '0;
            high_score <= '0;
            game_over  <= 1'b0;
            hit_cnt    <= '0;
        end else begin
            armed      <= ~start;
            puck_reset <= 1'b0;
            case (st)
                ST_IDLE, ST_OVER: begin
                    if (start_ev) begin
                        st         <= ST_SERVE;
                        score      <= '0;
                        lives      <= 2'(LIVES_INIT);
                        speed      <= 3'd1;
                        hit_cnt    <= '0;
                        puck_reset <= 1'b1;
                        game_over  <= 1'b0;
                    end
                end
                ST_SERVE: begin
                    if (t_done) begin
                        st      <= ST_PLAY;
                        play_en <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    // A miss in the same cycle as a hit wins; the hit is dropped.
                    if (miss) begin
                        lives   <= lives - 2'd1;
                        play_en <= 1'b0;
                        if (lives == 2'd1) begin
                            st        <= ST_OVER;
                            game_over <= 1'b1;
                            if (score > high_score)
                                high_score <= score;
                        end else begin
                            st <= ST_MISS;
                        end
                    end else if (hit) begin
                        score <= sat_inc16(score);
                        if (hit_cnt == 8'(SPEEDUP_EVERY - 1)) begin
                            hit_cnt <= '0;
                            if (speed != SPEED_MAX)
                                speed <= speed + 3'd1;
                        end else begin
                            hit_cnt <= hit_cnt + 8'd1;
                        end
                    end
                end
                ST_MISS: begin
                    if (t_done) begin
                        st         <= ST_SERVE;
                        puck_reset <= 1'b1;
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_game_controller.sv
module tb_game_controller;

    localparam int L  = 3;
    localparam int SF = 120;
    localparam int MF = 60;
    localparam int SE = 8;

    logic        clk, reset, start, frame_tick, hit, miss;
    logic [2:0]  state;
    logic        play_en, puck_reset, game_over;
    logic [2:0]  speed;
    logic [1:0]  lives;
    logic [15:0] score, high_score;

    int checks = 0;
    int errors = 0;

    game_controller #(
        .LIVES_INIT(L), .SERVE_FRAMES(SF), .MISS_FRAMES(MF), .SPEEDUP_EVERY(SE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .frame_tick(frame_tick),
        .hit(hit), .miss(miss), .state(state), .play_en(play_en),
        .puck_reset(puck_reset), .speed(speed), .lives(lives), .score(score),
        .high_score(high_score), .game_over(game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [42:0] dut_vec;
    assign dut_vec = {state, play_en, puck_reset, speed, lives, score, high_score, game_over};

    // ---------------- reference model (game rules, plain arithmetic) ----------
    // states: 0 idle, 1 serve, 2 play, 3 miss, 4 over
    int   m_state, m_speed, m_lives, m_score, m_high, m_hits, m_frames;
    logic m_preset, m_prev;

    task automatic model_reset();
        m_state = 0; m_speed = 0; m_lives = 0; m_score = 0; m_high = 0;
        m_hits = 0; m_frames = 0; m_preset = 1'b0;
        m_prev = 1'b1;  // a level already high at release is not a press
    endtask

    task automatic model_step(input logic s, input logic t, input logic h, input logic m);
        logic ev;
        ev = s && !m_prev;
        m_prev = s;
        m_preset = 1'b0;
        case (m_state)
            0, 4: if (ev) begin
                m_state = 1; m_score = 0; m_lives = L; m_speed = 1;
                m_hits = 0; m_frames = 0; m_preset = 1'b1;
            end
            1: if (t) begin
                m_frames++;
                if (m_frames == SF) begin m_state = 2; m_frames = 0; end
            end
            2: if (m) begin
                m_lives--;
                if (m_lives == 0) begin
                    m_state = 4;
                    if (m_score > m_high) m_high = m_score;
                end else begin
                    m_state = 3; m_frames = 0;
                end
            end else if (h) begin
                if (m_score < 65535) m_score++;
                m_hits++;
                if (m_hits == SE) begin
                    m_hits = 0;
                    if (m_speed < 7) m_speed++;
                end
            end
            3: if (t) begin
                m_frames++;
                if (m_frames == MF) begin m_state = 1; m_frames = 0; m_preset = 1'b1; end
            end
            default: ;
        endcase
    endtask

    function automatic logic [42:0] exp_vec();
        return {m_state[2:0], (m_state == 2), m_preset, m_speed[2:0], m_lives[1:0],
                m_score[15:0], m_high[15:0], (m_state == 4)};
    endfunction

    // Drive one cycle of inputs, advance the model, sample #1 after the edge.
    task automatic step(input logic s, input logic t, input logic h, input logic m);
        start = s; frame_tick = t; hit = h; miss = m;
        model_step(s, t, h, m);
        @(posedge clk);
        #1;
    endtask

    // Random frame ticks (plus ignored hit/miss/start noise outside PLAY)
    // until the model reaches the target state or the budget runs out.
    task automatic run_to(input int target, input int budget, output bit ok);
        for (int i = 0; i < budget && m_state != target; i++) begin
            logic nz;
            nz = (m_state != 2);
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 nz & 1'($urandom_range(0, 1)), nz & 1'($urandom_range(0, 1)));
        end
        ok = (m_state == target);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1; start = 0; frame_tick = 0; hit = 0; miss = 0;
        model_reset();
        @(posedge clk); #1;
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++; $display("FAIL reset_state: got %h exp %h", dut_vec, exp_vec());
        end
        reset = 1'b0;
    endtask

    task automatic test_serve();
        bit ok;
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        checks++;
        if (state !== 3'd1 || puck_reset !== 1'b1 || lives !== 2'd3 || speed !== 3'd1) begin
            errors++; $display("FAIL serve_entry: got st=%0d pr=%0d lv=%0d sp=%0d exp 1 1 3 1",
                                state, puck_reset, lives, speed);
        end
        step(1, 1, 0, 0);
        checks++;
        if (puck_reset !== 1'b0 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL serve_pulse_len: got %h exp %h", dut_vec, exp_vec());
        end
        run_to(2, 2000, ok);
        checks++;
        if (!ok || play_en !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL serve_to_play: ok=%0d got %h exp %h", ok, dut_vec, exp_vec());
        end
    endtask

    task automatic test_speed();
        int n[3] = '{8, 56, 10};
        int es[3] = '{2, 7, 7};
        int sc[3] = '{8, 64, 74};
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < n[p]; i++) begin
                repeat ($urandom_range(0, 2)) step(0, 1'($urandom_range(0, 1)), 0, 0);
                step(0, 1'($urandom_range(0, 1)), 1, 0);
                checks++;
                if (dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL speed_hit: got %h exp %h", dut_vec, exp_vec());
                end
            end
            checks++;
            if (speed !== es[p][2:0] || score !== sc[p][15:0]) begin
                errors++; $display("FAIL speed_level: got sp=%0d sc=%0d exp sp=%0d sc=%0d",
                                    speed, score, es[p], sc[p]);
            end
        end
    endtask

    task automatic test_game_over();
        bit ok;
        for (int k = 0; k < 3; k++) begin
            step(0, 0, 0, 1);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL over_miss: got %h exp %h", dut_vec, exp_vec());
            end
            if (k < 2) begin
                run_to(1, 1000, ok);
                checks++;
                if (!ok || puck_reset !== 1'b1 || dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL over_reserve: ok=%0d got %h exp %h", ok, dut_vec, exp_vec());
                end
                run_to(2, 2000, ok);
                checks++;
                if (!ok || dut_vec !== exp_vec()) begin
                    errors++; $display("FAIL over_replay: ok=%0d got %h exp %h", ok, dut_vec, exp_vec());
                end
            end
        end
        checks++;
        if (state !== 3'd4 || game_over !== 1'b1 || high_score !== 16'd74) begin
            errors++; $display("FAIL over_high: got st=%0d go=%0d hs=%0d exp 4 1 74",
                                state, game_over, high_score);
        end
    endtask

    task automatic test_hit_miss();
        bit ok;
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        run_to(2, 2000, ok);
        repeat (5) begin
            step(0, 0, 1, 0);
            step(0, 1'($urandom_range(0, 1)), 0, 0);
        end
        step(0, 0, 1, 1);
        checks++;
        if (score !== 16'd5 || lives !== 2'd2 || state !== 3'd3 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL hit_miss_same: got %h exp %h", dut_vec, exp_vec());
        end
        run_to(1, 1000, ok);
        checks++;
        if (!ok || state !== 3'd1 || puck_reset !== 1'b1 || score !== 16'd5) begin
            errors++; $display("FAIL miss_to_serve: ok=%0d got %h exp %h", ok, dut_vec, exp_vec());
        end
        run_to(2, 2000, ok);
        step(0, 0, 0, 1);
        run_to(1, 1000, ok);
        run_to(2, 2000, ok);
        step(0, 0, 0, 1);
        checks++;
        if (!ok || state !== 3'd4 || high_score !== 16'd74 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL lower_keeps_high: got %h exp %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_reset_midgame();
        bit ok;
        step(0, 0, 0, 0);
        step(1, 0, 0, 0);
        run_to(2, 2000, ok);
        repeat (20) step(0, 0, 1, 0);
        checks++;
        if (score !== 16'd20 || dut_vec !== exp_vec()) begin
            errors++; $display("FAIL mid_score: got %h exp %h", dut_vec, exp_vec());
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (dut_vec !== 43'd0 || high_score !== 16'd0) begin
            errors++; $display("FAIL async_reset: got %h exp 0", dut_vec);
        end
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_start_held();
        int ticks = 0;
        start = 1'b1;
        reset = 1'b1;
        model_reset();
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 500 && ticks < 10; i++) begin
            logic t;
            t = 1'($urandom_range(0, 1));
            ticks += int'(t);
            step(1, t, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            checks++;
            if (state !== 3'd0 || dut_vec !== exp_vec()) begin
                errors++; $display("FAIL start_held_idle: got %h exp %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 2) == 0),
                 1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 59) == 0));
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++; $display("FAIL random_cycle %0d: got %h exp %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_serve();
        test_speed();
        test_game_over();
        test_hit_miss();
        test_reset_midgame();
        test_start_held();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
